mem_bus_adapter: RTL

//   Load/store bus adapter between the multicycle core's control/datapath and a 32-bit memory bus with wait states.

---
 rtl/mem_bus_pkg.sv | 47 ++++
 rtl/mem_load_align.sv | 27 ++
 rtl/mem_bus_adapter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the load/store bus adapter: access-size codes, FSM
// state encoding and byte-lane steering helpers.
package mem_bus_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Half accesses only look at addr[1]; words always cover all four lanes.
  function automatic logic [3:0] lane_sel(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   lane_sel = 4'b0001 << addr;
      2'b01:   lane_sel = addr[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
    case (funct3)
      MEM_B, MEM_H, MEM_W: funct3_illegal = 1'b0;
      MEM_BU, MEM_HU:      funct3_illegal = write;
      default:             funct3_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_bus_pkg::*;
(
  input  logic [31:0] dat_i,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [15:0] half;
  logic        sx;

  always_comb begin
    shifted = dat_i >> {addr_lo, 3'b000};
    half    = addr_lo[1] ? dat_i[31:16] : dat_i[15:0];
    sx      = ~funct3[2];
    case (funct3[1:0])
      2'b00:   rdata = {{24{sx & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata = {{16{sx & half[15]}}, half};
      default: rdata = dat_i;
    endcase
  end

endmodule

// File: rtl/mem_bus_adapter.sv
// Load/store adapter running one handshaked bus cycle per request, with timeout.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word requests error without a bus cycle.
module mem_bus_adapter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_adr,
  output logic [3:0]            bus_sel,
  output logic [31:0]           bus_dat_o,
  input  logic [31:0]           bus_dat_i,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  bus_stb_q, bus_stb_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_adr_q, bus_adr_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [31:0]           bus_dat_o_q, bus_dat_o_d;
  logic [31:0]           load_data;
  logic                  req_bad;
  logic                  timeout_hit;

  mem_load_align u_load_align (
    .dat_i   (bus_dat_i),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .rdata   (load_data)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign req_bad = funct3_illegal(req_write, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_bad = funct3_illegal(req_write, req_funct3);
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    addr_lo_d   = addr_lo_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    bus_stb_d   = bus_stb_q;
    bus_we_d    = bus_we_q;
    bus_adr_d   = bus_adr_q;
    bus_sel_d   = bus_sel_q;
    bus_dat_o_d = bus_dat_o_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d        = req_funct3;
          addr_lo_d   = req_addr[1:0];
          bus_we_d    = req_write;
          bus_adr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_sel_d   = lane_sel(req_funct3, req_addr[1:0]);
          bus_dat_o_d = lane_wdata(req_funct3, req_wdata);
          cnt_d       = '0;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = ACCESS;
            bus_stb_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        // An error response takes priority over an ack in the same cycle.
        if (bus_ack || bus_err) begin
          state_d     = RESP;
          bus_stb_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus_err;
          rsp_rdata_d = (!bus_err && !bus_we_q) ? load_data : '0;
        end else if (timeout_hit) begin
          state_d     = RESP;
          bus_stb_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        bus_stb_d   = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_stb_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_adr_q   <= '0;
      bus_sel_q   <= '0;
      bus_dat_o_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      addr_lo_q   <= addr_lo_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_stb_q   <= bus_stb_d;
      bus_we_q    <= bus_we_d;
      bus_adr_q   <= bus_adr_d;
      bus_sel_q   <= bus_sel_d;
      bus_dat_o_q <= bus_dat_o_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_stb   = bus_stb_q;
  assign bus_we    = bus_we_q;
  assign bus_adr   = bus_adr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_dat_o = bus_dat_o_q;

endmodule
